// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS-subset decode stage:
// opcodes, functs, ALU-op encoding, FSM states and stage records.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22,
                         FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
                         FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLT = 4'd6,  ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA = 4'd10, ALU_LUI = 4'd11,
    ALU_PASS = 4'd12
  } alu_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    alu_op_e     alu_op;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        use_imm;
    logic        reserved;
    logic        is_beq;
    logic        is_bne;
    logic        is_jump;
    logic        is_jal;
    logic        uses_rs;
    logic        uses_rt;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    alu_op_e     alu_op;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        use_imm;
    logic [2:0]  ic;
  } idex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch/register-file/ID-EX signal bundle around the decode stage.
// slave is the decode stage's view, master is the surrounding pipeline's view.
interface id_stage_if;
  logic [31:0] inst;
  logic [31:0] ID_PC;
  logic [1:0]  IC_IF;
  logic        int_flush;
  logic        EX_mem_read;
  logic [4:0]  EX_rt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic        delay;
  logic        branch;
  logic        J;
  logic [31:0] LA_inst;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;

  logic [31:0] EX_PC;
  logic [3:0]  EX_alu_op;
  logic [31:0] EX_imm;
  logic [31:0] EX_rs_val;
  logic [31:0] EX_rt_val;
  logic [4:0]  EX_dest;
  logic        EX_reg_write;
  logic        EX_mem_read_o;
  logic        EX_mem_write;
  logic        EX_use_imm;
  logic [2:0]  IC_ID;

  modport slave (
    input  inst, ID_PC, IC_IF, int_flush, EX_mem_read, EX_rt, rs_val, rt_val,
    output delay, branch, J, LA_inst, rs_addr, rt_addr,
    output EX_PC, EX_alu_op, EX_imm, EX_rs_val, EX_rt_val, EX_dest,
    output EX_reg_write, EX_mem_read_o, EX_mem_write, EX_use_imm, IC_ID
  );

  modport master (
    output inst, ID_PC, IC_IF, int_flush, EX_mem_read, EX_rt, rs_val, rt_val,
    input  delay, branch, J, LA_inst, rs_addr, rt_addr,
    input  EX_PC, EX_alu_op, EX_imm, EX_rs_val, EX_rt_val, EX_dest,
    input  EX_reg_write, EX_mem_read_o, EX_mem_write, EX_use_imm, IC_ID
  );
endinterface

// File: rtl/id_decoder.sv
// Purely combinational instruction decode: ALU op, immediate form,
// destination, write/memory flags and which source registers are read.
module id_decoder
  import mips_pkg::*;
(
  input  logic [31:0] i_inst,
  output dec_t        o_dec
);

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm16;
  logic        w_itype;
  logic        w_writes;
  dec_t        w_dec;

  assign w_op    = i_inst[31:26];
  assign w_rd    = i_inst[15:11];
  assign w_shamt = i_inst[10:6];
  assign w_funct = i_inst[5:0];
  assign w_imm16 = i_inst[15:0];
  assign w_itype = w_op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI,
                                OP_XORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE};

  always_comb begin
    w_dec        = '0;
    w_dec.alu_op = ALU_PASS;
    w_writes     = 1'b0;
    if (i_inst != 32'h0) begin
      case (w_op)
        OP_RTYPE: begin
          w_dec.imm     = {27'h0, w_shamt};
          w_dec.dest    = w_rd;
          w_dec.uses_rs = 1'b1;
          w_dec.uses_rt = 1'b1;
          w_writes      = 1'b1;
          case (w_funct)
            FN_ADD, FN_ADDU: w_dec.alu_op = ALU_ADD;
            FN_SUB, FN_SUBU: w_dec.alu_op = ALU_SUB;
            FN_AND:  w_dec.alu_op = ALU_AND;
            FN_OR:   w_dec.alu_op = ALU_OR;
            FN_XOR:  w_dec.alu_op = ALU_XOR;
            FN_NOR:  w_dec.alu_op = ALU_NOR;
            FN_SLT:  w_dec.alu_op = ALU_SLT;
            FN_SLTU: w_dec.alu_op = ALU_SLTU;
            FN_SLL:  begin w_dec.alu_op = ALU_SLL; w_dec.uses_rs = 1'b0; end
            FN_SRL:  begin w_dec.alu_op = ALU_SRL; w_dec.uses_rs = 1'b0; end
            FN_SRA:  begin w_dec.alu_op = ALU_SRA; w_dec.uses_rs = 1'b0; end
            default: w_dec.reserved = 1'b1;
          endcase
        end
        OP_ADDI, OP_ADDIU: begin w_dec.alu_op = ALU_ADD; w_dec.imm = sext16(w_imm16); end
        OP_SLTI: begin w_dec.alu_op = ALU_SLT; w_dec.imm = sext16(w_imm16); end
        OP_ANDI: begin w_dec.alu_op = ALU_AND; w_dec.imm = {16'h0, w_imm16}; end
        OP_ORI:  begin w_dec.alu_op = ALU_OR;  w_dec.imm = {16'h0, w_imm16}; end
        OP_XORI: begin w_dec.alu_op = ALU_XOR; w_dec.imm = {16'h0, w_imm16}; end
        OP_LUI:  begin w_dec.alu_op = ALU_LUI; w_dec.imm = {w_imm16, 16'h0}; end
        OP_LW:   begin w_dec.alu_op = ALU_ADD; w_dec.imm = sext16(w_imm16); w_dec.mem_read = 1'b1; end
        OP_SW:   begin w_dec.alu_op = ALU_ADD; w_dec.imm = sext16(w_imm16); w_dec.mem_write = 1'b1; end
        OP_BEQ:  begin w_dec.alu_op = ALU_SUB; w_dec.imm = sext16(w_imm16); w_dec.is_beq = 1'b1; end
        OP_BNE:  begin w_dec.alu_op = ALU_SUB; w_dec.imm = sext16(w_imm16); w_dec.is_bne = 1'b1; end
        OP_J:    w_dec.is_jump = 1'b1;
        OP_JAL:  begin
          w_dec.is_jump = 1'b1;
          w_dec.is_jal  = 1'b1;
          w_dec.dest    = 5'd31;
          w_writes      = 1'b1;
        end
        default: w_dec.reserved = 1'b1;
      endcase
      // I-types that read rt (SW, BEQ, BNE) are exactly those that do not write it.
      if (w_itype) begin
        w_dec.uses_rs = (w_op != OP_LUI);
        w_dec.uses_rt = w_dec.mem_write | w_dec.is_beq | w_dec.is_bne;
        w_dec.use_imm = !(w_dec.is_beq | w_dec.is_bne);
        if (!w_dec.uses_rt) begin
          w_dec.dest = i_inst[20:16];
          w_writes   = 1'b1;
        end
      end
    end
    if (w_dec.reserved) begin
      w_dec          = '0;
      w_dec.alu_op   = ALU_PASS;
      w_dec.reserved = 1'b1;
      w_writes       = 1'b0;
    end
    w_dec.reg_write = w_writes && (w_dec.dest != 5'd0);
    w_dec.rs        = i_inst[25:21];
    w_dec.rt        = i_inst[20:16];
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/id_stage.sv
// Decode stage: load-use stall FSM, branch resolution and the ID/EX
// pipeline register, around the combinational id_decoder.
module id_stage
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  id_stage_if.slave  bus
);

  dec_t   w_dec;
  idex_t  w_issue;
  idex_t  w_flush;
  idex_t  r_idex;
  state_e r_state;
  logic   w_hazard;
  logic   w_bubble;
  logic   w_quiet;
  logic   w_taken;

  id_decoder u_decoder (
    .i_inst (bus.inst),
    .o_dec  (w_dec)
  );

  assign bus.LA_inst = bus.inst;
  assign bus.rs_addr = w_dec.rs;
  assign bus.rt_addr = w_dec.rt;

  assign w_hazard = bus.EX_mem_read && (bus.EX_rt != 5'd0) &&
                    ((w_dec.uses_rs && (bus.EX_rt == w_dec.rs)) ||
                     (w_dec.uses_rt && (bus.EX_rt == w_dec.rt)));

  // Only RUN can bubble, so each instruction stalls at most once.
  assign w_bubble = (r_state == ST_RUN) && w_hazard && !bus.int_flush && !reset;
  assign w_quiet  = w_bubble || bus.int_flush || reset;
  assign w_taken  = w_dec.is_jump ||
                    (w_dec.is_beq && (bus.rs_val == bus.rt_val)) ||
                    (w_dec.is_bne && (bus.rs_val != bus.rt_val));

  assign bus.delay  = w_bubble;
  assign bus.branch = w_taken && !w_quiet;
  assign bus.J      = w_dec.is_jump && !w_quiet;

  always_comb begin
    w_issue.pc        = w_dec.is_jal ? (bus.ID_PC + 32'd8) : bus.ID_PC;
    w_issue.alu_op    = w_dec.alu_op;
    w_issue.imm       = w_dec.imm;
    w_issue.rs_val    = bus.rs_val;
    w_issue.rt_val    = bus.rt_val;
    w_issue.dest      = w_dec.dest;
    w_issue.reg_write = w_dec.reg_write;
    w_issue.mem_read  = w_dec.mem_read;
    w_issue.mem_write = w_dec.mem_write;
    w_issue.use_imm   = w_dec.use_imm;
    w_issue.ic        = {w_dec.reserved, bus.IC_IF};
  end

  // A flush keeps only the exception PC and the fetch exception code.
  always_comb begin
    w_flush    = '0;
    w_flush.pc = bus.ID_PC;
    w_flush.ic = {1'b0, bus.IC_IF};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_idex  <= '0;
    end else if (bus.int_flush) begin
      r_state <= ST_RUN;
      r_idex  <= w_flush;
    end else if ((r_state == ST_RUN) && w_hazard) begin
      r_state <= ST_STALL;
      r_idex  <= '0;
    end else begin
      r_state <= ST_RUN;
      r_idex  <= w_issue;
    end
  end

  assign bus.EX_PC         = r_idex.pc;
  assign bus.EX_alu_op     = r_idex.alu_op;
  assign bus.EX_imm        = r_idex.imm;
  assign bus.EX_rs_val     = r_idex.rs_val;
  assign bus.EX_rt_val     = r_idex.rt_val;
  assign bus.EX_dest       = r_idex.dest;
  assign bus.EX_reg_write  = r_idex.reg_write;
  assign bus.EX_mem_read_o = r_idex.mem_read;
  assign bus.EX_mem_write  = r_idex.mem_write;
  assign bus.EX_use_imm    = r_idex.use_imm;
  assign bus.IC_ID         = r_idex.ic;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios then random instruction streams,
// checked against a mnemonic-level reference model with a fetch stage that holds on delay.
module tb_id_stage;
  import mips_pkg::*;

  typedef enum int {
    K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU,
    K_SLL, K_SRL, K_SRA,
    K_ADDI, K_ADDIU, K_SLTI, K_ANDI, K_ORI, K_XORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
    K_J, K_JAL, K_NOP, K_RES, K_RESF, K_NUM
  } kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ui;
    logic [2:0]  ic;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    exp_t        e;
    logic        urs, urt, beq, bne, jmp;
  } ref_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   txn = 0;
  logic m_bubbled = 1'b0;
  logic last_delay = 1'b0;

  id_stage_if bus ();

  id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected decode written per mnemonic from the ISA, with literal MIPS encodings.
  function automatic ref_t model(input kind_e k, input logic [4:0] rs, rt, rd, sh,
                                 input logic [15:0] imm, input logic [25:0] tgt,
                                 input logic [31:0] pc, rsv, rtv, input logic [1:0] icif);
    ref_t r;
    logic [31:0] sx, zx;
    logic [5:0] code;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0, imm};
    code = 6'h00;
    r.inst = 32'h0;
    r.urs = 0; r.urt = 0; r.beq = 0; r.bne = 0; r.jmp = 0;
    r.e = '0;
    r.e.pc = pc; r.e.rsv = rsv; r.e.rtv = rtv; r.e.ic = {1'b0, icif};
    r.e.alu = ALU_PASS;
    case (k)
      K_ADD:   begin code = 6'h20; r.e.alu = ALU_ADD;  end
      K_ADDU:  begin code = 6'h21; r.e.alu = ALU_ADD;  end
      K_SUB:   begin code = 6'h22; r.e.alu = ALU_SUB;  end
      K_SUBU:  begin code = 6'h23; r.e.alu = ALU_SUB;  end
      K_AND:   begin code = 6'h24; r.e.alu = ALU_AND;  end
      K_OR:    begin code = 6'h25; r.e.alu = ALU_OR;   end
      K_XOR:   begin code = 6'h26; r.e.alu = ALU_XOR;  end
      K_NOR:   begin code = 6'h27; r.e.alu = ALU_NOR;  end
      K_SLT:   begin code = 6'h2A; r.e.alu = ALU_SLT;  end
      K_SLTU:  begin code = 6'h2B; r.e.alu = ALU_SLTU; end
      K_SLL:   begin code = 6'h00; r.e.alu = ALU_SLL;  end
      K_SRL:   begin code = 6'h02; r.e.alu = ALU_SRL;  end
      K_SRA:   begin code = 6'h03; r.e.alu = ALU_SRA;  end
      K_ADDI:  begin code = 6'h08; r.e.alu = ALU_ADD; r.e.imm = sx; end
      K_ADDIU: begin code = 6'h09; r.e.alu = ALU_ADD; r.e.imm = sx; end
      K_SLTI:  begin code = 6'h0A; r.e.alu = ALU_SLT; r.e.imm = sx; end
      K_ANDI:  begin code = 6'h0C; r.e.alu = ALU_AND; r.e.imm = zx; end
      K_ORI:   begin code = 6'h0D; r.e.alu = ALU_OR;  r.e.imm = zx; end
      K_XORI:  begin code = 6'h0E; r.e.alu = ALU_XOR; r.e.imm = zx; end
      K_LUI:   begin code = 6'h0F; r.e.alu = ALU_LUI; r.e.imm = {imm, 16'h0}; end
      K_LW:    begin code = 6'h23; r.e.alu = ALU_ADD; r.e.imm = sx; r.e.mr = 1; end
      K_SW:    begin code = 6'h2B; r.e.alu = ALU_ADD; r.e.imm = sx; r.e.mw = 1; end
      K_BEQ:   begin code = 6'h04; r.e.alu = ALU_SUB; r.e.imm = sx; r.beq = 1; end
      K_BNE:   begin code = 6'h05; r.e.alu = ALU_SUB; r.e.imm = sx; r.bne = 1; end
      K_J:     begin r.inst = {6'h02, tgt}; r.jmp = 1; end
      K_JAL:   begin r.inst = {6'h03, tgt}; r.jmp = 1; r.e.dest = 31; r.e.rw = 1; r.e.pc = pc + 32'd8; end
      K_RES:   begin r.inst = {6'h3F, tgt}; r.e.ic[2] = 1; end
      K_RESF:  begin r.inst = {6'h00, rs, rt, rd, sh, 6'h3F}; r.e.ic[2] = 1; end
      default: r.inst = 32'h0;
    endcase
    if (k <= K_SRA) begin
      r.inst = {6'h00, rs, rt, rd, sh, code};
      r.e.imm = {27'h0, sh};
      r.e.dest = rd;
      r.e.rw = (rd != 0);
      r.urs = !(k inside {K_SLL, K_SRL, K_SRA});
      r.urt = 1;
      if (r.inst == 32'h0) begin
        r.e.alu = ALU_PASS;
        r.urt = 0;
      end
    end else if (k >= K_ADDI && k <= K_BNE) begin
      r.inst = {code, rs, rt, imm};
      r.urs = (k != K_LUI);
      r.urt = k inside {K_SW, K_BEQ, K_BNE};
      r.e.ui = !(k inside {K_BEQ, K_BNE});
      if (k inside {K_ADDI, K_ADDIU, K_SLTI, K_ANDI, K_ORI, K_XORI, K_LUI, K_LW}) begin
        r.e.dest = rt;
        r.e.rw = (rt != 0);
      end
    end
    return r;
  endfunction

  task automatic run_cycle(input kind_e k, input logic [4:0] rs, rt, rd, sh,
                           input logic [15:0] imm, input logic [25:0] tgt,
                           input logic [31:0] pc, rsv, rtv, input logic [1:0] icif,
                           input logic intv, rstv, mr, input logic [4:0] ert);
    ref_t r;
    exp_t e, obs;
    logic haz, taken, x_delay, x_branch, x_j;
    r = model(k, rs, rt, rd, sh, imm, tgt, pc, rsv, rtv, icif);
    bus.inst = r.inst; bus.ID_PC = pc; bus.IC_IF = icif; bus.int_flush = intv;
    bus.EX_mem_read = mr; bus.EX_rt = ert; bus.rs_val = rsv; bus.rt_val = rtv;
    reset = rstv;
    haz = mr && (ert != 0) && ((r.urs && ert == r.inst[25:21]) || (r.urt && ert == r.inst[20:16]));
    x_delay  = haz && !m_bubbled && !intv && !rstv;
    taken    = r.jmp || (r.beq && rsv == rtv) || (r.bne && rsv != rtv);
    x_branch = taken && !x_delay && !intv && !rstv;
    x_j      = r.jmp && !x_delay && !intv && !rstv;
    #2;
    chk("delay", bus.delay, x_delay);
    chk("branch", bus.branch, x_branch);
    chk("J", bus.J, x_j);
    chk("rs_addr", bus.rs_addr, r.inst[25:21]);
    chk("rt_addr", bus.rt_addr, r.inst[20:16]);
    chk("LA_inst", bus.LA_inst, r.inst);
    if (rstv) begin
      e = '0; m_bubbled = 0;
    end else if (intv) begin
      e = '0; e.pc = pc; e.ic = {1'b0, icif}; m_bubbled = 0;
    end else if (x_delay) begin
      e = '0; m_bubbled = 1;
    end else begin
      e = r.e; m_bubbled = 0;
    end
    last_delay = x_delay;
    @(posedge clk);
    #1;
    obs = {bus.EX_PC, bus.EX_alu_op, bus.EX_imm, bus.EX_rs_val, bus.EX_rt_val, bus.EX_dest,
           bus.EX_reg_write, bus.EX_mem_read_o, bus.EX_mem_write, bus.EX_use_imm, bus.IC_ID};
    chk("idex", obs, e);
    $display("txn %0d inst=%08h pc=%08h int=%0b rst=%0b ld=%0b/%0d delay=%0b branch=%0b J=%0b EX_dest=%0d EX_PC=%08h IC_ID=%03b",
             txn, r.inst, pc, intv, rstv, mr, ert, bus.delay, x_branch, x_j, bus.EX_dest, bus.EX_PC, bus.IC_ID);
    txn++;
  endtask

  initial begin
    kind_e k;
    logic [4:0] rs, rt, rd, sh, ert;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] pc, rsv, rtv;
    logic [1:0] icif;
    logic intv, rstv, mr;

    reset = 1'b1;
    bus.inst = '0; bus.ID_PC = '0; bus.IC_IF = '0; bus.int_flush = 1'b0;
    bus.EX_mem_read = 1'b0; bus.EX_rt = '0; bus.rs_val = '0; bus.rt_val = '0;
    @(posedge clk);
    #1;

    // reset state
    run_cycle(K_ADD, 1, 2, 3, 0, 0, 0, 32'h10, 32'h5, 32'h6, 2'b11, 0, 1, 1, 1);
    run_cycle(K_JAL, 0, 0, 0, 0, 0, 26'h10, 32'h10, 0, 0, 2'b00, 0, 1, 0, 0);

    // ADDI $9,$0,5
    run_cycle(K_ADDI, 0, 9, 0, 0, 16'd5, 0, 32'h4, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("addi_dest", bus.EX_dest, 5'd9);
    chk("addi_imm", bus.EX_imm, 32'd5);
    chk("addi_rw", bus.EX_reg_write, 1'b1);
    chk("addi_useimm", bus.EX_use_imm, 1'b1);

    // load-use hazard on ADD $10,$8,$9
    run_cycle(K_ADD, 8, 9, 10, 0, 0, 0, 32'h8, 32'd11, 32'd22, 2'b00, 0, 0, 1, 8);
    chk("haz_bubble_dest", bus.EX_dest, 5'd0);
    chk("haz_bubble_pc", bus.EX_PC, 32'h0);
    run_cycle(K_ADD, 8, 9, 10, 0, 0, 0, 32'h8, 32'd11, 32'd22, 2'b00, 0, 0, 1, 8);
    chk("haz_issue_dest", bus.EX_dest, 5'd10);
    chk("haz_issue_rsval", bus.EX_rs_val, 32'd11);
    run_cycle(K_ADD, 8, 0, 11, 0, 0, 0, 32'hC, 32'd1, 32'd2, 2'b00, 0, 0, 1, 8);
    run_cycle(K_ADD, 8, 0, 11, 0, 0, 0, 32'hC, 32'd1, 32'd2, 2'b00, 0, 0, 1, 8);

    // BEQ $8,$9 taken / not taken
    run_cycle(K_BEQ, 8, 9, 0, 0, 16'd3, 0, 32'h20, 32'd7, 32'd7, 2'b00, 0, 0, 0, 0);
    run_cycle(K_BEQ, 8, 9, 0, 0, 16'd3, 0, 32'h24, 32'd7, 32'd6, 2'b00, 0, 0, 0, 0);
    chk("beq_imm", bus.EX_imm, 32'd3);

    // JAL link
    run_cycle(K_JAL, 0, 0, 0, 0, 0, 26'h10, 32'h100, 0, 0, 2'b00, 0, 0, 0, 0);
    chk("jal_pc", bus.EX_PC, 32'h108);
    chk("jal_dest", bus.EX_dest, 5'd31);

    // reserved instruction then interrupt flush overriding a hazard
    run_cycle(K_RES, 0, 0, 0, 0, 0, 26'h0, 32'h200, 32'd3, 32'd4, 2'b00, 0, 0, 0, 0);
    chk("res_ic", bus.IC_ID, 3'b100);
    chk("res_rw", bus.EX_reg_write, 1'b0);
    run_cycle(K_ADD, 8, 9, 10, 0, 0, 0, 32'h40, 32'd1, 32'd2, 2'b10, 1, 0, 1, 8);
    chk("int_ic", bus.IC_ID, 3'b010);
    chk("int_pc", bus.EX_PC, 32'h40);
    chk("int_dest", bus.EX_dest, 5'd0);

    // reset while stalled, then interrupt while stalled
    run_cycle(K_SW, 9, 9, 0, 0, 16'hFFF0, 0, 32'h60, 32'd5, 32'd6, 2'b00, 0, 0, 1, 9);
    run_cycle(K_SW, 9, 9, 0, 0, 16'hFFF0, 0, 32'h60, 32'd5, 32'd6, 2'b00, 0, 1, 1, 9);
    chk("rst_stall_pc", bus.EX_PC, 32'h0);
    run_cycle(K_SW, 9, 9, 0, 0, 16'hFFF0, 0, 32'h60, 32'd5, 32'd6, 2'b00, 0, 0, 1, 9);
    run_cycle(K_SW, 9, 9, 0, 0, 16'hFFF0, 0, 32'h60, 32'd5, 32'd6, 2'b00, 0, 0, 1, 9);
    chk("sw_imm", bus.EX_imm, 32'hFFFF_FFF0);
    run_cycle(K_BNE, 4, 5, 0, 0, 16'h8, 0, 32'h70, 32'd1, 32'd2, 2'b00, 0, 0, 1, 5);
    run_cycle(K_BNE, 4, 5, 0, 0, 16'h8, 0, 32'h70, 32'd1, 32'd2, 2'b01, 1, 0, 1, 5);
    run_cycle(K_BNE, 4, 5, 0, 0, 16'h8, 0, 32'h70, 32'd1, 32'd2, 2'b00, 0, 0, 1, 5);

    // random stream; the fetch stage re-presents the instruction while delay is high
    k = K_NOP; rs = 0; rt = 0; rd = 0; sh = 0; imm = 0; tgt = 0; pc = 0;
    for (int n = 0; n < 400; n++) begin
      if (!last_delay) begin
        k   = kind_e'($urandom_range(0, int'(K_NUM) - 1));
        rs  = 5'($urandom_range(0, 31));
        rt  = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        sh  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        tgt = 26'($urandom);
        pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
        if ($urandom_range(0, 9) == 0) begin
          rs = 0; rt = 0; rd = 0; sh = 0;
        end
      end
      rsv  = $urandom;
      rtv  = ($urandom_range(0, 2) == 0) ? rsv : $urandom;
      icif = 2'($urandom_range(0, 3));
      intv = ($urandom_range(0, 15) == 0);
      rstv = ($urandom_range(0, 31) == 0);
      mr   = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: ert = rs;
        1: ert = rt;
        2: ert = 5'($urandom_range(0, 31));
        default: ert = 5'd0;
      endcase
      run_cycle(k, rs, rt, rd, sh, imm, tgt, pc, rsv, rtv, icif, intv, rstv, mr, ert);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
